req_arbiter8: RTL

- Sequential 8-requester arbiter that shares one downstream resource (bus/port) among eight requesters.
- Fixed-priority mode: bit 7 highest, bit 0 lowest, consistent with the team's 8-to-3 priority encoding convention.
- Round-robin mode: priority rotates past the last winner.
- Registered one-hot grant plus encoded index; grant held until release, request drop, or hold-timeout.

---
 rtl/arb_pkg.sv | 32 +++
 rtl/arb_rr_pick8.sv | 58 +++++
 rtl/req_arbiter8.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//
// Purpose:
//    Shared types, sizes and a small helper for the 8-requester arbiter.
//
// Contents:
//    NUM_REQ        number of requesters (8)
//    IDX_W          width of a requester index (3)
//    arb_state_t    arbiter FSM state (IDLE, GRANT)
//    req_vec_t      one bit per requester
//    idx_t          binary requester index
//    idx_to_onehot  index -> one-hot requester vector
// -----------------------------------------------------------------------------
package arb_pkg;

   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   typedef logic [NUM_REQ-1:0] req_vec_t;
   typedef logic [IDX_W-1:0]   idx_t;

   function automatic req_vec_t idx_to_onehot(input idx_t idx);
      return req_vec_t'(1) << idx;
   endfunction

endpackage

// File: rtl/arb_rr_pick8.sv
// -----------------------------------------------------------------------------
// arb_rr_pick8
//
// Purpose:
//    Combinational rotating-priority picker for eight requesters.
//    In round-robin mode the search order is start_idx-1, start_idx-2, ...,
//    start_idx (mod 8); in fixed mode the rotation is forced to zero, so the
//    order is 7 down to 0. A sole requester always wins.
//
// Ports:
//    req        in   8  request vector
//    start_idx  in   3  index of the previous winner (rotation point)
//    rr_mode    in   1  1 = rotate by start_idx, 0 = fixed priority
//    any        out  1  at least one request is present
//    idx        out  3  winning index (meaningful only when any = 1)
// -----------------------------------------------------------------------------
module arb_rr_pick8
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   start_idx,
   input  logic               rr_mode,
   output logic               any,
   output logic [IDX_W-1:0]   idx
);

   idx_t     start_eff;
   req_vec_t rot;
   idx_t     rot_pos;

   assign start_eff = rr_mode ? start_idx : '0;

   // rot[j] = req[(j + start) mod 8]; this puts req[start-1] on bit 7 and
   // req[start] on bit 0, so a plain "highest bit wins" encoder yields the
   // desired round-robin order.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
         idx_t src;
         assign src     = idx_t'(gi) + start_eff;
         assign rot[gi] = req[src];
      end
   endgenerate

   // Priority encoder, bit 7 highest: later (higher) hits overwrite earlier.
   always_comb begin
      rot_pos = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rot[i]) begin
            rot_pos = idx_t'(i);
         end
      end
   end

   // Un-rotate; the 3-bit add wraps modulo 8.
   assign idx = rot_pos + start_eff;
   assign any = |req;

endmodule

// File: rtl/req_arbiter8.sv
// -----------------------------------------------------------------------------
// req_arbiter8
//
// Purpose:
//    Sequential arbiter sharing one downstream resource among eight
//    requesters. Fixed priority (bit 7 highest) or round-robin (priority
//    rotates past the last winner). The grant is registered and held until
//    the owner releases, drops its request, or holds for MAX_HOLD cycles.
//    Every grant is followed by at least one idle cycle before re-arbitration.
//
// Parameters:
//    MAX_HOLD     maximum consecutive grant cycles (2..256)
//    HC_W         hold-counter width, derived from MAX_HOLD
//
// Ports:
//    clk          in   1  clock, rising edge
//    rst          in   1  asynchronous active-high reset
//    req          in   8  request vector, held high while wanted
//    rr_mode      in   1  1 = round-robin, 0 = fixed; sampled at arbitration
//    rel          in   1  owner's done pulse; ends the current grant
//                         ("release" is a reserved word, hence the short name)
//    gnt          out  8  registered one-hot grant
//    gnt_idx      out  3  index of the granted requester, 0 when idle
//    gnt_valid    out  1  a grant is active
//    gnt_timeout  out  1  one-cycle pulse: previous grant hit MAX_HOLD
// -----------------------------------------------------------------------------
module req_arbiter8
   import arb_pkg::*;
#(
   parameter  int MAX_HOLD = 16,
   localparam int HC_W     = $clog2(MAX_HOLD)
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               rr_mode,
   input  logic               rel,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid,
   output logic               gnt_timeout
);

   // ---------------------------------------------------------------- state
   arb_state_t      state_reg,       state_next;
   logic [HC_W-1:0] hold_cnt_reg,    hold_cnt_next;
   idx_t            last_idx_reg,    last_idx_next;
   req_vec_t        gnt_reg,         gnt_next;
   idx_t            gnt_idx_reg,     gnt_idx_next;
   logic            gnt_valid_reg,   gnt_valid_next;
   logic            gnt_timeout_reg, gnt_timeout_next;

   // ---------------------------------------------------------------- picker
   logic pick_any;
   idx_t pick_idx;

   arb_rr_pick8 u_pick (
      .req       (req),
      .start_idx (last_idx_reg),
      .rr_mode   (rr_mode),
      .any       (pick_any),
      .idx       (pick_idx)
   );

   // ---------------------------------------------------------------- grant end conditions
   // Owner-driven termination takes precedence over the hold limit, so a
   // release on the final allowed cycle never produces a timeout pulse.
   logic end_by_owner;
   logic hold_last;

   assign end_by_owner = rel || !req[gnt_idx_reg];
   assign hold_last    = (hold_cnt_reg == HC_W'(MAX_HOLD - 1));

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         hold_cnt_reg    <= '0;
         last_idx_reg    <= '0;
         gnt_reg         <= '0;
         gnt_idx_reg     <= '0;
         gnt_valid_reg   <= 1'b0;
         gnt_timeout_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         hold_cnt_reg    <= hold_cnt_next;
         last_idx_reg    <= last_idx_next;
         gnt_reg         <= gnt_next;
         gnt_idx_reg     <= gnt_idx_next;
         gnt_valid_reg   <= gnt_valid_next;
         gnt_timeout_reg <= gnt_timeout_next;
      end
   end

   // ---------------------------------------------------------------- next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (pick_any) begin
               state_next = GRANT;
            end
         end
         GRANT: begin
            if (end_by_owner || hold_last) begin
               state_next = IDLE;
            end
         end
      endcase
   end

   // ---------------------------------------------------------------- output / datapath logic
   // Computes the values loaded into the output registers at the next edge.
   // Anything not explicitly held defaults to the idle (cleared) value,
   // which is what produces the mandatory dead cycle after every grant.
   always_comb begin
      gnt_next         = '0;
      gnt_idx_next     = '0;
      gnt_valid_next   = 1'b0;
      gnt_timeout_next = 1'b0;
      hold_cnt_next    = hold_cnt_reg;
      last_idx_next    = last_idx_reg;
      case (state_reg)
         IDLE: begin
            if (pick_any) begin
               gnt_next       = idx_to_onehot(pick_idx);
               gnt_idx_next   = pick_idx;
               gnt_valid_next = 1'b1;
               hold_cnt_next  = '0;
               last_idx_next  = pick_idx;
            end
         end
         GRANT: begin
            if (end_by_owner) begin
               hold_cnt_next = '0;
            end else if (hold_last) begin
               hold_cnt_next    = '0;
               gnt_timeout_next = 1'b1;
            end else begin
               gnt_next       = gnt_reg;
               gnt_idx_next   = gnt_idx_reg;
               gnt_valid_next = 1'b1;
               hold_cnt_next  = hold_cnt_reg + HC_W'(1);
            end
         end
      endcase
   end

   // ---------------------------------------------------------------- outputs
   assign gnt         = gnt_reg;
   assign gnt_idx     = gnt_idx_reg;
   assign gnt_valid   = gnt_valid_reg;
   assign gnt_timeout = gnt_timeout_reg;

endmodule
